// File: rtl/sim_result_mailbox.sv
// Memory-mapped simulation result mailbox: sticky pass/fail latch, scratch register and a
// console byte FIFO drained through a ready/valid stream.
module sim_result_mailbox #(
    parameter logic [7:0]  PASS_CODE  = 8'h6d,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cs,
    input  logic       i_we,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_done,
    output logic       o_pass,
    output logic [7:0] o_result_code,
    output logic       o_con_valid,
    output logic [7:0] o_con_data,
    input  logic       i_con_ready
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [1:0] ADDR_RESULT  = 2'd0;
    localparam logic [1:0] ADDR_CONSOLE = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_SCRATCH = 2'd3;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_overflow;
    logic        r_done;
    logic        r_pass;
    logic [7:0]  r_result_code;
    logic [7:0]  r_scratch;
    logic [7:0]  r_data;

    logic        w_wr;
    logic        w_rd;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic [AW:0] w_level;
    logic [8:0]  w_level_ext;
    logic [7:0]  w_level_byte;
    logic [7:0]  w_rd_data;

    assign w_wr = i_cs & i_we;
    assign w_rd = i_cs & ~i_we;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign w_pop      = ~w_empty & i_con_ready;
    assign w_push_req = w_wr && (i_addr == ADDR_CONSOLE);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr  = w_wr && (i_addr == ADDR_STATUS) && i_data[2];

    assign w_level      = r_wr_ptr - r_rd_ptr;
    assign w_level_ext  = 9'(w_level);
    assign w_level_byte = w_level_ext[8] ? 8'hff : w_level_ext[7:0];

    always_comb begin
        w_rd_data = 8'h00;
        case (i_addr)
            ADDR_RESULT:  w_rd_data = r_result_code;
            ADDR_CONSOLE: w_rd_data = w_level_byte;
            ADDR_STATUS:  w_rd_data = {3'b000, r_pass, r_done, r_overflow, w_full, w_empty};
            ADDR_SCRATCH: w_rd_data = r_scratch;
            default:      w_rd_data = 8'h00;
        endcase
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_result_code <= 8'h00;
            r_scratch     <= 8'h00;
            r_data        <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_wr && (i_addr == ADDR_RESULT) && !r_done) begin
                r_done        <= 1'b1;
                r_result_code <= i_data;
                r_pass        <= (i_data == PASS_CODE);
            end
            if (w_wr && (i_addr == ADDR_SCRATCH)) begin
                r_scratch <= i_data;
            end
            if (w_rd) begin
                r_data <= w_rd_data;
            end
        end
    end

    assign o_data        = r_data;
    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_result_code = r_result_code;
    assign o_con_valid   = ~w_empty;
    assign o_con_data    = r_mem[r_rd_ptr[AW-1:0]];

endmodule
